// File: rtl/col2img_pkg.sv
// Shared types and helpers for the col2img accumulator: default widths,
// FSM state encoding and patch-geometry helpers.
package col2img_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_IMG_SIZE   = 5;
  localparam int DEF_ACC_WIDTH  = DEF_DATA_WIDTH + 5;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  // Number of patch origins along one dimension.
  function automatic logic [2:0] n_out(input logic [2:0] k, input logic stride,
                                       input int img_size);
    int diff;
    diff = img_size - int'(k);
    return 3'((diff >> stride) + 1);
  endfunction

  function automatic logic is_legal_k(input logic [2:0] k,
                                      input int img_size = DEF_IMG_SIZE);
    return (k != 3'd0) && (int'(k) <= img_size);
  endfunction

endpackage

// File: rtl/col2img_addr_gen.sv
// Nested patch/element counters that walk the column stream back onto
// image coordinates (row-major patches, row-major elements within a patch).
module col2img_addr_gen
  import col2img_pkg::*;
#(
  parameter int IMG_SIZE = DEF_IMG_SIZE,
  parameter int CW       = $clog2(IMG_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  input  logic [2:0]    k,
  input  logic          stride,
  output logic [CW-1:0] r,
  output logic [CW-1:0] c,
  output logic          last
);

  logic [2:0] r_i, r_j, r_pc, r_pr;
  logic [2:0] w_kmax, w_nmax;
  logic       w_j_end, w_i_end, w_pc_end, w_pr_end;
  logic [2:0] w_r_full, w_c_full;

  assign w_kmax   = k - 3'd1;
  assign w_nmax   = n_out(k, stride, IMG_SIZE) - 3'd1;
  assign w_j_end  = (r_j == w_kmax);
  assign w_i_end  = (r_i == w_kmax);
  assign w_pc_end = (r_pc == w_nmax);
  assign w_pr_end = (r_pr == w_nmax);
  assign last     = w_j_end && w_i_end && w_pc_end && w_pr_end;

  // Origin is the patch index scaled by the stride (1 or 2).
  assign w_r_full = (stride ? {r_pr[1:0], 1'b0} : r_pr) + r_i;
  assign w_c_full = (stride ? {r_pc[1:0], 1'b0} : r_pc) + r_j;
  assign r        = CW'(w_r_full);
  assign c        = CW'(w_c_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i  <= '0;
      r_j  <= '0;
      r_pc <= '0;
      r_pr <= '0;
    end else if (clear) begin
      r_i  <= '0;
      r_j  <= '0;
      r_pc <= '0;
      r_pr <= '0;
    end else if (advance) begin
      r_j <= w_j_end ? 3'd0 : r_j + 3'd1;
      if (w_j_end) begin
        r_i <= w_i_end ? 3'd0 : r_i + 3'd1;
        if (w_i_end) begin
          r_pc <= w_pc_end ? 3'd0 : r_pc + 3'd1;
          if (w_pc_end) begin
            r_pr <= w_pr_end ? 3'd0 : r_pr + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/col2img.sv
// col2img: accumulates a stream of per-patch column elements back into an
// IMG_SIZE x IMG_SIZE image and hands the finished frame out via valid/ready.
module col2img
  import col2img_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_SIZE   = DEF_IMG_SIZE,
  parameter int ACC_WIDTH  = DATA_WIDTH + 5
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [2:0]                                     k,
  input  logic                                           stride,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [DATA_WIDTH-1:0]                          in_data,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [IMG_SIZE-1:0][IMG_SIZE-1:0][ACC_WIDTH-1:0] out_img,
  output logic                                           busy,
  output logic                                           cfg_err
);

  localparam int CW = $clog2(IMG_SIZE);

  state_t                                           r_state, w_state_next;
  logic [2:0]                                       r_k;
  logic                                             r_stride;
  logic                                             r_cfg_err;
  logic [IMG_SIZE-1:0][IMG_SIZE-1:0][ACC_WIDTH-1:0] r_img;
  logic [CW-1:0]                                    w_r, w_c;
  logic                                             w_last, w_accept, w_clear;
  logic [ACC_WIDTH-1:0]                             w_ext;

  assign w_ext = {{(ACC_WIDTH-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_clear      = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && is_legal_k(k, IMG_SIZE)) begin
          w_clear      = 1'b1;
          w_state_next = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid && w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_stride  <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cfg_err <= (r_state == IDLE) && start && !is_legal_k(k, IMG_SIZE);
      if (w_clear) begin
        r_k      <= k;
        r_stride <= stride;
      end
    end
  end

  // Image stays untouched outside ACCUM so the frame is held through DONE/IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_img <= '0;
    end else if (w_clear) begin
      r_img <= '0;
    end else if (w_accept) begin
      r_img[w_r][w_c] <= r_img[w_r][w_c] + w_ext;
    end
  end

  col2img_addr_gen #(
    .IMG_SIZE (IMG_SIZE),
    .CW       (CW)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_clear),
    .advance (w_accept),
    .k       (r_k),
    .stride  (r_stride),
    .r       (w_r),
    .c       (w_c),
    .last    (w_last)
  );

  assign out_img = r_img;
  assign busy    = (r_state != IDLE);
  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_col2img.sv
// Randomized scoreboard bench for col2img: a geometric reference model
// predicts each frame, a monitor compares on every out_valid/out_ready handshake.
module tb_col2img;

  localparam int DW = 8;
  localparam int IS = 5;
  localparam int AW = DW + 5;

  typedef logic [IS-1:0][IS-1:0][AW-1:0] img_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    k = 3'd0;
  logic          stride = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  img_t          out_img;
  logic          busy;
  logic          cfg_err;

  img_t exp_q[$];
  img_t last_exp = '0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   frames_pushed = 0;
  int   frames_seen = 0;

  col2img dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k         (k),
    .stride    (stride),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_img   (out_img),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic ok, input longint act, input longint exp);
    n_checks++;
    if (ok === 1'b1) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: each beat index is decomposed arithmetically into patch origin and offset.
  function automatic img_t model(input int kk, input int ss, input int d[$]);
    int   acc[IS][IS];
    img_t m;
    int   n, per, patch, e, pr, pc, i, j;
    foreach (acc[r, c]) acc[r][c] = 0;
    n   = ((IS - kk) >> ss) + 1;
    per = kk * kk;
    foreach (d[idx]) begin
      patch = idx / per;
      e     = idx % per;
      pr    = patch / n;
      pc    = patch % n;
      i     = e / kk;
      j     = e % kk;
      acc[pr * (ss + 1) + i][pc * (ss + 1) + j] += d[idx];
    end
    for (int r = 0; r < IS; r++)
      for (int c = 0; c < IS; c++)
        m[r][c] = AW'(acc[r][c]);
    return m;
  endfunction

  always @(negedge clk) begin
    img_t e;
    int   br, bc;
    logic ok;
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 1'b0, 1, 0);
      end else begin
        e  = exp_q.pop_front();
        frames_seen++;
        ok = (out_img === e);
        br = 0;
        bc = 0;
        for (int r = IS - 1; r >= 0; r--)
          for (int c = IS - 1; c >= 0; c--)
            if (out_img[r][c] !== e[r][c]) begin br = r; bc = c; end
        check($sformatf("frame%0d_px[%0d][%0d]", frames_seen, br, bc), ok,
              $signed(out_img[br][bc]), $signed(e[br][bc]));
      end
    end
  end

  task automatic px(input string name, input int r, input int c, input int exp);
    check(name, $signed(out_img[r][c]) == exp, $signed(out_img[r][c]), exp);
  endtask

  task automatic do_start(input int kk, input int ss);
    start  = 1'b1;
    k      = 3'(kk);
    stride = ss[0];
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic stream(input int d[$], input int rand_valid, input int check_last);
    int sent = 0;
    int budget = 0;
    bit acc;
    while (sent < d.size()) begin
      in_valid = (rand_valid != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = DW'(d[sent]);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc && check_last != 0 && sent == d.size() - 1)
        check("out_valid_low_on_last_beat", out_valid == 1'b0, out_valid, 0);
      @(posedge clk); #1;
      if (acc) sent++;
      budget++;
      if (budget > 2000) begin
        check("stream_timeout", 1'b0, sent, d.size());
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic run_frame(input int kk, input int ss, input int d[$], input int rand_valid,
                           input int hold, input int poke_start);
    img_t snap;
    int   wait_cnt;
    last_exp = model(kk, ss, d);
    exp_q.push_back(last_exp);
    frames_pushed++;
    do_start(kk, ss);
    check("busy_after_start", busy == 1'b1, busy, 1);
    stream(d, rand_valid, 1);
    check("out_valid_after_last", out_valid == 1'b1, out_valid, 1);
    for (int h = 0; h < hold; h++) begin
      snap = out_img;
      if (poke_start != 0) begin start = 1'b1; k = 3'd3; end
      @(posedge clk); #1;
      start = 1'b0;
      check($sformatf("done_hold_cycle%0d", h),
            (out_img === snap) && out_valid && !in_ready && busy, in_ready, 0);
    end
    out_ready = 1'b1;
    wait_cnt  = 0;
    while (out_valid !== 1'b1 && wait_cnt < 50) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after_ready", !busy && !out_valid, {busy, out_valid}, 0);
  endtask

  initial begin
    int d[$];
    int kk, ss, n;

    repeat (3) @(posedge clk);
    #1;
    check("reset_img_zero", out_img === '0, out_img[0][0], 0);
    check("reset_flags", {in_ready, out_valid, busy, cfg_err} === 4'b0,
          {in_ready, out_valid, busy, cfg_err}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-size kernel: single patch, ramp data.
    d = {};
    for (int b = 0; b < 25; b++) d.push_back(b + 1);
    run_frame(5, 0, d, 0, 0, 0);
    px("t1_px00", 0, 0, 1);
    px("t1_px23", 2, 3, 14);
    px("t1_px44", 4, 4, 25);

    // k=3 stride 1, all ones: coverage counts.
    d = {};
    for (int b = 0; b < 81; b++) d.push_back(1);
    run_frame(3, 0, d, 0, 0, 0);
    px("t2_px00", 0, 0, 1);
    px("t2_px02", 0, 2, 3);
    px("t2_px11", 1, 1, 4);
    px("t2_px22", 2, 2, 9);
    px("t2_px44", 4, 4, 1);

    // k=3 stride 2, all minus one.
    d = {};
    for (int b = 0; b < 36; b++) d.push_back(-1);
    run_frame(3, 1, d, 0, 0, 0);
    px("t3_px22", 2, 2, -4);
    px("t3_px02", 0, 2, -2);
    px("t3_px11", 1, 1, -1);
    px("t3_px44", 4, 4, -1);

    // k=1 stride 2, random valid gaps, held DONE with start poked.
    d = {};
    for (int b = 0; b < 9; b++) d.push_back(int'($urandom_range(1, 100)));
    run_frame(1, 1, d, 1, 5, 1);
    px("t4_px01", 0, 1, 0);
    px("t4_px11", 1, 1, 0);
    px("t4_px44", 4, 4, d[8]);

    // Illegal k values.
    for (int t = 0; t < 2; t++) begin
      start = 1'b1;
      k     = (t == 0) ? 3'd0 : 3'd6;
      @(posedge clk); #1;
      start = 1'b0;
      check($sformatf("cfg_err_pulse_k%0d", k), cfg_err && !busy, {cfg_err, busy}, 2);
      @(posedge clk); #1;
      check($sformatf("cfg_err_drop_k%0d", k), !cfg_err && !busy, {cfg_err, busy}, 0);
      check("cfg_err_img_held", out_img === last_exp, out_img[0][0], last_exp[0][0]);
    end

    // Abort a frame with reset after 10 beats.
    d = {};
    for (int b = 0; b < 10; b++) d.push_back(int'($urandom_range(1, 50)));
    do_start(3, 0);
    stream(d, 0, 0);
    rst = 1'b1;
    #2;
    check("abort_img_zero", out_img === '0, out_img[0][0], 0);
    check("abort_flags", {in_ready, out_valid, busy} === 3'b0, {in_ready, out_valid, busy}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_valid", out_valid == 1'b0, out_valid, 0);

    d = {};
    for (int b = 0; b < 25; b++) d.push_back(b + 1);
    run_frame(5, 0, d, 0, 0, 0);
    px("t6_px23", 2, 3, 14);

    // Random frames.
    for (int f = 0; f < 6; f++) begin
      kk = int'($urandom_range(1, 5));
      ss = int'($urandom_range(0, 1));
      n  = ((IS - kk) >> ss) + 1;
      d  = {};
      for (int b = 0; b < n * n * kk * kk; b++) d.push_back(int'($urandom_range(0, 255)) - 128);
      run_frame(kk, ss, d, 1, int'($urandom_range(0, 3)), 0);
    end

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", (exp_q.size() == 0) && (frames_seen == frames_pushed),
          frames_seen, frames_pushed);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
